// File: rtl/dm_ctrl_if.sv
// CPU <-> data-memory stage bundle: request/store side from the CPU, load data,
// completion, error and stall back from the memory stage.
interface dm_ctrl_if;
    logic        req;
    logic        we;
    logic [2:0]  mem_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic        stall;

    modport master (
        output req, we, mem_type, addr, wdata,
        input  rdata, done, err, stall
    );

    modport slave (
        input  req, we, mem_type, addr, wdata,
        output rdata, done, err, stall
    );
endinterface

// File: rtl/dm_ctrl.sv
// Data-memory stage: word array with wait states, byte/half/word loads and stores.
// Define DM_ALIGN_CHECK_EN to flag misaligned word/half accesses instead of aligning them.
module dm_ctrl #(
    parameter int ADDR_W      = 7,
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    dm_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [2:0]          type_q, type_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [31:0]         mem [2**ADDR_W];

    logic                accept, enter_done, misaligned, mem_we;
    logic                cur_we;
    logic [2:0]          cur_type;
    logic [ADDR_W+1:0]   cur_addr;
    logic [31:0]         cur_wdata;
    logic                is_half, is_byte, is_signed;
    logic [ADDR_W-1:0]   idx;
    logic [31:0]         mem_word, load_val, lane_wdata, wr_word;
    logic [15:0]         half_sel;
    logic [7:0]          byte_sel;
    logic [3:0]          be;
    logic                unused_addr_bits;

    // Upper address bits wrap; they never reach the array.
    assign unused_addr_bits = ^bus.addr[31:ADDR_W+2];

    // The accepting edge can also be the completing edge, so use live inputs in IDLE.
    assign accept    = (state_q == IDLE) && bus.req;
    assign cur_we    = accept ? bus.we                : we_q;
    assign cur_type  = accept ? bus.mem_type          : type_q;
    assign cur_addr  = accept ? bus.addr[ADDR_W+1:0]  : addr_q;
    assign cur_wdata = accept ? bus.wdata             : wdata_q;

    assign is_half   = (cur_type == 3'b001) || (cur_type == 3'b010);
    assign is_byte   = (cur_type == 3'b011) || (cur_type == 3'b100);
    assign is_signed = (cur_type == 3'b001) || (cur_type == 3'b011);
    assign idx       = cur_addr[ADDR_W+1:2];

`ifdef DM_ALIGN_CHECK_EN
    assign misaligned = is_half ? cur_addr[0] : (!is_byte && (cur_addr[1:0] != 2'b00));
`else
    // Lane selection below already ignores the low bits a word/half cannot use.
    assign misaligned = 1'b0;
`endif

    assign mem_word = mem[idx];
    assign half_sel = cur_addr[1] ? mem_word[31:16] : mem_word[15:0];
    assign byte_sel = mem_word[{cur_addr[1:0], 3'b000} +: 8];

    always_comb begin
        load_val = mem_word;
        if (is_half)
            load_val = is_signed ? {{16{half_sel[15]}}, half_sel} : {16'h0000, half_sel};
        else if (is_byte)
            load_val = is_signed ? {{24{byte_sel[7]}}, byte_sel} : {24'h000000, byte_sel};
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign be[gi] = is_byte ? (cur_addr[1:0] == 2'(gi))
                      : (is_half ? (cur_addr[1] == (gi >= 2)) : 1'b1);
        assign lane_wdata[8*gi +: 8] = is_byte ? cur_wdata[7:0]
                      : (is_half ? cur_wdata[8*(gi%2) +: 8] : cur_wdata[8*gi +: 8]);
        assign wr_word[8*gi +: 8] = be[gi] ? lane_wdata[8*gi +: 8] : mem_word[8*gi +: 8];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        type_d  = type_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    type_d  = bus.mem_type;
                    addr_d  = bus.addr[ADDR_W+1:0];
                    wdata_d = bus.wdata;
                    if (misaligned || (WAIT_CYCLES == 0)) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = 4'(WAIT_CYCLES);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1)
                    state_d = DONE;
            end
            DONE: begin
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        enter_done = (state_d == DONE) && (state_q != DONE);
        mem_we     = enter_done && cur_we && !misaligned;
        done_d     = enter_done;
        err_d      = enter_done && misaligned;
        rdata_d    = rdata_q;
        if (enter_done)
            rdata_d = (cur_we || misaligned) ? 32'h0 : load_val;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            type_q  <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Array contents survive reset; only a completing store touches them.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[idx] <= wr_word;
    end

    assign bus.rdata = rdata_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.stall = accept || (state_q == WAIT);
endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench: one instance with two wait states, one with none.
module tb_dm_ctrl;
    logic clk;
    logic rstn2, rstn0;
    int   checks = 0;
    int   errors = 0;

    dm_ctrl_if bus2();
    dm_ctrl_if bus0();

    dm_ctrl #(.ADDR_W(7), .WAIT_CYCLES(2)) u_w2 (.clk(clk), .rstn(rstn2), .bus(bus2));
    dm_ctrl #(.ADDR_W(7), .WAIT_CYCLES(0)) u_w0 (.clk(clk), .rstn(rstn0), .bus(bus0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DM_ALIGN_CHECK_EN
    localparam logic [31:0] MIS_ERR = 32'd1;
    localparam logic [31:0] MIS_LAT = 32'd1;
    localparam logic [31:0] LW13_RD = 32'h0;
    localparam logic [31:0] W10_RD  = 32'hDEADBEEF;
`else
    localparam logic [31:0] MIS_ERR = 32'd0;
    localparam logic [31:0] MIS_LAT = 32'd3;
    localparam logic [31:0] LW13_RD = 32'hDEADBEEF;
    localparam logic [31:0] W10_RD  = 32'h12345678;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge in IDLE; returns one cycle after the done cycle, req low.
    task automatic acc2(input string tag, input logic w, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic [31:0] exp_err,
                        input logic [31:0] exp_lat);
        int cyc = 0;
        int stall_cnt = 0;
        int done_cyc = -1;
        bus2.req = 1'b1; bus2.we = w; bus2.mem_type = t; bus2.addr = a; bus2.wdata = d;
        #1;
        while (cyc < 20 && done_cyc < 0) begin
            if (bus2.stall) stall_cnt++;
            if (bus2.done) done_cyc = cyc;
            else begin
                @(negedge clk); #1;
                cyc++;
            end
        end
        chk({tag, "_latency"}, 32'(done_cyc), exp_lat);
        chk({tag, "_stall"}, 32'(stall_cnt), exp_lat);
        chk({tag, "_rdata"}, bus2.rdata, exp_rd);
        chk({tag, "_err"}, {31'd0, bus2.err}, exp_err);
        $display("txn %s: we=%0b type=%0d addr=%h wdata=%h -> rdata=%h err=%0b done_cycle=%0d",
                 tag, w, t, a, d, bus2.rdata, bus2.err, done_cyc);
        bus2.req = 1'b0;
        @(negedge clk);
    endtask

    logic        b_we   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  b_type [5] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b100};
    logic [31:0] b_addr [5] = '{32'h04, 32'h04, 32'h08, 32'h08, 32'h05};
    logic [31:0] b_wd   [5] = '{32'hA5A5A5A5, 32'h0, 32'h0BADF00D, 32'h0, 32'h0};
    logic [31:0] b_exp  [5] = '{32'h0, 32'hA5A5A5A5, 32'h0, 32'h0BADF00D, 32'h000000A5};

    initial begin
        rstn2 = 1'b0; rstn0 = 1'b0;
        bus2.req = 1'b0; bus2.we = 1'b0; bus2.mem_type = 3'b000; bus2.addr = 32'h0; bus2.wdata = 32'h0;
        bus0.req = 1'b0; bus0.we = 1'b0; bus0.mem_type = 3'b000; bus0.addr = 32'h0; bus0.wdata = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_done", {31'd0, bus2.done}, 32'd0);
        chk("rst_err", {31'd0, bus2.err}, 32'd0);
        chk("rst_rdata", bus2.rdata, 32'h0);
        chk("rst_stall", {31'd0, bus2.stall}, 32'd0);
        rstn2 = 1'b1; rstn0 = 1'b1;
        @(negedge clk);

        acc2("sw10", 1'b1, 3'b000, 32'h10, 32'hDEADBEEF, 32'h0, 32'd0, 32'd3);
        acc2("lw10", 1'b0, 3'b000, 32'h10, 32'h0, 32'hDEADBEEF, 32'd0, 32'd3);

        acc2("sw20", 1'b1, 3'b000, 32'h20, 32'h11223344, 32'h0, 32'd0, 32'd3);
        acc2("sb21", 1'b1, 3'b011, 32'h21, 32'h000000F0, 32'h0, 32'd0, 32'd3);
        acc2("lb21", 1'b0, 3'b011, 32'h21, 32'h0, 32'hFFFFFFF0, 32'd0, 32'd3);
        acc2("lbu21", 1'b0, 3'b100, 32'h21, 32'h0, 32'h000000F0, 32'd0, 32'd3);
        acc2("lw20", 1'b0, 3'b000, 32'h20, 32'h0, 32'h1122F044, 32'd0, 32'd3);

        acc2("sw30", 1'b1, 3'b000, 32'h30, 32'h0, 32'h0, 32'd0, 32'd3);
        acc2("sh32", 1'b1, 3'b001, 32'h32, 32'h00008001, 32'h0, 32'd0, 32'd3);
        acc2("lh32", 1'b0, 3'b001, 32'h32, 32'h0, 32'hFFFF8001, 32'd0, 32'd3);
        acc2("lhu32", 1'b0, 3'b010, 32'h32, 32'h0, 32'h00008001, 32'd0, 32'd3);
        acc2("lw30", 1'b0, 3'b000, 32'h30, 32'h0, 32'h80010000, 32'd0, 32'd3);

        // Unusual encodings: 111 acts as word, store type 100 acts as 011.
        acc2("sw50_t7", 1'b1, 3'b111, 32'h50, 32'hCAFEF00D, 32'h0, 32'd0, 32'd3);
        acc2("sb51_t4", 1'b1, 3'b100, 32'h51, 32'h000000AB, 32'h0, 32'd0, 32'd3);
        acc2("lw50", 1'b0, 3'b000, 32'h50, 32'h0, 32'hCAFEAB0D, 32'd0, 32'd3);

        acc2("lw13_mis", 1'b0, 3'b000, 32'h13, 32'h0, LW13_RD, MIS_ERR, MIS_LAT);
        acc2("sw12_mis", 1'b1, 3'b000, 32'h12, 32'h12345678, 32'h0, MIS_ERR, MIS_LAT);
        acc2("lw10_after", 1'b0, 3'b000, 32'h10, 32'h0, W10_RD, 32'd0, 32'd3);
        acc2("lw210_wrap", 1'b0, 3'b000, 32'h210, 32'h0, W10_RD, 32'd0, 32'd3);

        acc2("sw40", 1'b1, 3'b000, 32'h40, 32'h11111111, 32'h0, 32'd0, 32'd3);
        acc2("lw40", 1'b0, 3'b000, 32'h40, 32'h0, 32'h11111111, 32'd0, 32'd3);

        // Store aborted by reset while in the wait state.
        bus2.req = 1'b1; bus2.we = 1'b1; bus2.mem_type = 3'b000; bus2.addr = 32'h40; bus2.wdata = 32'h5A5A5A5A;
        @(negedge clk); #1;
        chk("abort_wait_stall", {31'd0, bus2.stall}, 32'd1);
        rstn2 = 1'b0; bus2.req = 1'b0;
        #1;
        chk("abort_rst_done", {31'd0, bus2.done}, 32'd0);
        chk("abort_rst_stall", {31'd0, bus2.stall}, 32'd0);
        chk("abort_rst_rdata", bus2.rdata, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("abort_rst_done2", {31'd0, bus2.done}, 32'd0);
        chk("abort_rst_stall2", {31'd0, bus2.stall}, 32'd0);
        $display("txn abort: reset during WAIT of sw 0x40");
        rstn2 = 1'b1;
        @(negedge clk);
        acc2("lw40_post_rst", 1'b0, 3'b000, 32'h40, 32'h0, 32'h11111111, 32'd0, 32'd3);

        // Zero wait states, req held high across back-to-back accesses.
        bus0.req = 1'b1; bus0.we = b_we[0]; bus0.mem_type = b_type[0];
        bus0.addr = b_addr[0]; bus0.wdata = b_wd[0];
        #1;
        for (int c = 0; c < 10; c++) begin
            chk("b2b_done", {31'd0, bus0.done}, 32'(c % 2));
            chk("b2b_stall", {31'd0, bus0.stall}, 32'(1 - (c % 2)));
            if (c % 2 == 1) begin
                chk("b2b_rdata", bus0.rdata, b_exp[c/2]);
                chk("b2b_err", {31'd0, bus0.err}, 32'd0);
                $display("txn b2b%0d: we=%0b addr=%h -> rdata=%h", c/2, b_we[c/2], b_addr[c/2], bus0.rdata);
                if (c/2 < 4) begin
                    bus0.we = b_we[c/2+1]; bus0.mem_type = b_type[c/2+1];
                    bus0.addr = b_addr[c/2+1]; bus0.wdata = b_wd[c/2+1];
                end
            end
            @(negedge clk); #1;
        end
        bus0.req = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
